// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 asynchronous serial transmitter, LSB first, clocked by the
// 16x (OVERSAMPLE x) baud clock shared with the receive path.
//
// Ports:
//   clkx16  in   oversampled baud clock, the only clock
//   reset   in   synchronous, active-high reset
//   data    in   [7:0] byte to transmit, sampled only in the acceptance cycle
//   send    in   transmit request, accepted when send=1 and ready=1
//   tx      out  serial line, idle high, registered
//   ready   out  idle and able to accept send, registered
//   done    out  one-cycle pulse when a frame has fully completed, registered
//
// Frame timing, with cycle 0 as the acceptance cycle:
//   start bit     cycles 1 .. OVERSAMPLE
//   data bit i    cycles OVERSAMPLE*(1+i)+1 .. OVERSAMPLE*(2+i)
//   stop bit(s)   cycles OVERSAMPLE*9+1 .. OVERSAMPLE*(9+STOP_BITS)
//   ready, done   cycle OVERSAMPLE*(9+STOP_BITS)+1

module uart_tx #(
    parameter int OVERSAMPLE = 16,  // 2..64
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic       clkx16,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [7:0]      shreg;
    logic            phase_end;

    assign phase_end = (phase == PHASE_LAST);

    // tx is updated on the same edge that changes state, so the line only
    // moves at bit boundaries and is never combinationally derived.
    always_ff @(posedge clkx16) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= 8'h00;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    if (send) begin
                        shreg    <= data;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b0;
                        ready    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (phase_end) begin
                        phase   <= '0;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DATA: begin
                    if (phase_end) begin
                        phase <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end else begin
                            // shreg[1] becomes bit 0 after this shift
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                STOP: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            ready <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: a default instance (1 stop bit) and a
// second instance with STOP_BITS=2, both on the same clock and reset.
// Cycle k is the clock period following edge k; outputs are sampled 1 time
// unit after each rising edge and inputs are driven at the same point.

module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data1, data2;
    logic       send1, send2;
    logic       tx1, ready1, done1;
    logic       tx2, ready2, done2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut1 (
        .clkx16(clk), .reset(reset), .data(data1), .send(send1),
        .tx(tx1), .ready(ready1), .done(done1)
    );

    uart_tx #(.OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
        .clkx16(clk), .reset(reset), .data(data2), .send(send2),
        .tx(tx2), .ready(ready2), .done(done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic o_tx(input bit sel);
        return sel ? tx2 : tx1;
    endfunction
    function automatic logic o_ready(input bit sel);
        return sel ? ready2 : ready1;
    endfunction
    function automatic logic o_done(input bit sel);
        return sel ? done2 : done1;
    endfunction

    task automatic set_send(input bit sel, input logic v);
        if (sel) send2 = v; else send1 = v;
    endtask
    task automatic set_data(input bit sel, input logic [7:0] v);
        if (sel) data2 = v; else data1 = v;
    endtask

    // Called in cycle 0 (send already asserted). Checks every cycle of the
    // frame, then ready=1/done=1 in cycle F+1. Optionally keeps send high
    // (hold), pulses send with 0x3C mid-frame (pulse_at), and rewrites data
    // at cycle 40 and at cycle F.
    task automatic frame(input bit sel, input logic [7:0] b, input int sb,
                         input bit hold, input int pulse_at,
                         input logic [7:0] mid_d, input logic [7:0] end_d);
        int   f;
        logic e;
        f = 16 * (9 + sb);
        for (int c = 1; c <= f; c++) begin
            step();
            if (c == 1 && !hold) set_send(sel, 1'b0);
            if (c == pulse_at) begin
                set_send(sel, 1'b1);
                set_data(sel, 8'h3C);
            end
            if (c == pulse_at + 1 && !hold) set_send(sel, 1'b0);
            if (c == 40) set_data(sel, mid_d);
            if (c == f) set_data(sel, end_d);
            if (c <= 16)       e = 1'b0;
            else if (c <= 144) e = b[(c - 17) / 16];
            else               e = 1'b1;
            chk("tx_bit", o_tx(sel), e);
            chk("ready_busy", o_ready(sel), 1'b0);
            chk("done_busy", o_done(sel), 1'b0);
        end
        step();
        chk("ready_end", o_ready(sel), 1'b1);
        chk("done_end", o_done(sel), 1'b1);
        chk("tx_end", o_tx(sel), 1'b1);
    endtask

    task automatic idle_check(input bit sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_tx"}, o_tx(sel), 1'b1);
            chk({tag, "_ready"}, o_ready(sel), 1'b1);
            chk({tag, "_done"}, o_done(sel), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        send1 = 1'b0; send2 = 1'b0;
        data1 = 8'h00; data2 = 8'h00;

        // Reset values
        step(); step(); step();
        reset = 1'b0;
        idle_check(1'b0, 200, "rst1");
        idle_check(1'b1, 10, "rst2");

        // Single byte 0xA5
        data1 = 8'hA5; send1 = 1'b1;
        frame(1'b0, 8'hA5, 1, 1'b0, 0, 8'h5A, 8'h00);
        step();
        chk("a5_done_low", done1, 1'b0);
        chk("a5_ready", ready1, 1'b1);
        idle_check(1'b0, 5, "gap1");

        // Back-to-back: 0x00 then 0xFF with send held; data 0x12 mid-frame
        data1 = 8'h00; send1 = 1'b1;
        frame(1'b0, 8'h00, 1, 1'b1, 0, 8'h12, 8'hFF);
        frame(1'b0, 8'hFF, 1, 1'b0, 0, 8'h00, 8'h00);
        step();
        chk("b2b_done_low", done1, 1'b0);
        idle_check(1'b0, 5, "gap2");

        // Busy ignore: send pulse with 0x3C during DATA
        data1 = 8'h96; send1 = 1'b1;
        frame(1'b0, 8'h96, 1, 1'b0, 50, 8'h69, 8'h00);
        idle_check(1'b0, 200, "busy");

        // Reset mid-frame at cycle 70
        data1 = 8'hC3; send1 = 1'b1;
        step();
        send1 = 1'b0;
        chk("rmid_start", tx1, 1'b0);
        for (int c = 2; c <= 70; c++) step();
        chk("rmid_busy", ready1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_tx", tx1, 1'b1);
        chk("rmid_ready", ready1, 1'b1);
        chk("rmid_done", done1, 1'b0);
        idle_check(1'b0, 200, "rmid_after");

        // Fresh send after the abandoned frame
        data1 = 8'h5A; send1 = 1'b1;
        frame(1'b0, 8'h5A, 1, 1'b0, 0, 8'hA5, 8'h00);
        step();
        chk("5a_done_low", done1, 1'b0);

        // Reset and send together: reset wins
        data1 = 8'hF0; send1 = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; send1 = 1'b0;
        chk("rs_ready", ready1, 1'b1);
        chk("rs_tx", tx1, 1'b1);
        idle_check(1'b0, 40, "rs_after");

        // Two stop bits: 0x3C, done at cycle 177
        data2 = 8'h3C; send2 = 1'b1;
        frame(1'b1, 8'h3C, 2, 1'b0, 0, 8'hC3, 8'h00);
        step();
        chk("sb2_done_low", done2, 1'b0);
        idle_check(1'b1, 5, "sb2_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
